// File: rtl/dmem_bus.sv
// dmem_bus: byte-addressed data memory with valid/ready requests, sized loads/stores,
// configurable read latency and error reporting.
module dmem_bus #(
    parameter int DEPTH_WORDS = 64,
    parameter int LAT         = 1,
    parameter int SNAP        = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [SNAP-1:0][31:0] dbg_mem
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    r_state;
    logic [2:0]    r_cnt;
    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [31:0]   r_rdata;
    logic          r_err;
    logic          w_acc;
    logic          w_err;
    logic          w_st;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic [31:0]   w_ld;
    logic [31:0]   w_wd;
    logic [3:0]    w_be;
    logic [7:0]    w_b;
    logic [15:0]   w_h;

    assign req_ready  = r_state != BUSY;
    assign resp_valid = r_state == RESP;
    assign resp_rdata = resp_valid ? r_rdata : '0;
    assign resp_err   = resp_valid & r_err;

    for (genvar g = 0; g < SNAP; g++) begin : g_dbg
        assign dbg_mem[g] = r_mem[g];
    end

    always_comb begin
        w_acc  = req_valid && req_ready;
        w_err  = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0])
              || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
              || {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);
        w_st   = w_acc && req_we && !w_err;
        w_idx  = req_addr[AW+1:2];
        w_word = r_mem[w_idx];
        w_b    = w_word[{req_addr[1:0], 3'b000} +: 8];
        w_h    = req_addr[1] ? w_word[31:16] : w_word[15:0];
        w_ld   = req_size == 2'b00 ? {{24{~req_unsigned & w_b[7]}}, w_b}
               : req_size == 2'b01 ? {{16{~req_unsigned & w_h[15]}}, w_h} : w_word;
        w_be   = req_size == 2'b00 ? 4'b0001 << req_addr[1:0]
               : req_size == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        w_wd   = req_size == 2'b00 ? {4{req_wdata[7:0]}}
               : req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    end

    // Load data is extracted from the word as it stands at the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
        end else begin
            if (w_acc) begin
                r_state <= (req_we || w_err || LAT == 0) ? RESP : BUSY;
                r_cnt   <= 3'(LAT == 0 ? 0 : LAT - 1);
                r_rdata <= (req_we || w_err) ? '0 : w_ld;
                r_err   <= w_err;
            end else if (r_state == BUSY) begin
                r_state <= r_cnt == 3'd0 ? RESP : BUSY;
                r_cnt   <= r_cnt - 3'd1;
            end else begin
                r_state <= IDLE;
            end
            if (w_st)
                for (int k = 0; k < 4; k++)
                    if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_wd[8*k +: 8];
        end
    end
endmodule

// File: tb/tb_dmem_bus.sv
// tb_dmem_bus: directed checks of dmem_bus at latencies 1 (main), 0, 3, 7 and 5
// sharing one request stream.
module tb_dmem_bus;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic        req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rdy [5];
    logic        rv [5];
    logic        er [5];
    logic [31:0] rd [5];
    logic [9:0][31:0] dbg [5];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        dmem_bus #(
            .DEPTH_WORDS(64),
            .LAT(g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 3 : g == 3 ? 7 : 5),
            .SNAP(10)
        ) u_dut (
            .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[g]),
            .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
            .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv[g]),
            .resp_rdata(rd[g]), .resp_err(er[g]), .dbg_mem(dbg[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1;
        req_we = we;
        req_size = sz;
        req_unsigned = uns;
        req_addr = a;
        req_wdata = wd;
    endtask

    // One request on the main (LAT=1) instance; lat counts cycles after the accept edge.
    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdo, output logic erro, output int lat);
        @(negedge clk);
        drive(we, sz, uns, a, wd);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 99;
        rdo = '0;
        erro = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rv[0]) begin
                lat = c;
                rdo = rd[0];
                erro = er[0];
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic e;
        int l;
        int nr;
        int first [5];
        int nlow [5];
        int nresp [5];
        logic [31:0] got [5];
        int lats [5] = '{1, 0, 3, 7, 5};
        logic        ev_we [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0]  ev_sz [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
        logic [31:0] ev_a [4] = '{32'h5, 32'h6, 32'h8, 32'h100};
        int          ev_w [4] = '{1, 1, 2, 0};
        logic [31:0] ev_m [4] = '{32'h5A5A5A5A, 32'h5A5A5A5A, 32'hDE112233, 32'h12345678};

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(rv[0]), 0);
        check("rst_rdata", rd[0], 0);
        check("rst_ready", 32'(rdy[0]), 1);
        check("rst_mem2", dbg[0][2], 0);
        @(negedge clk) reset = 1'b0;

        xact(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, d, e, l);
        check("sw_lat", l, 1);
        check("sw_err", 32'(e), 0);
        check("sw_rdata", d, 0);
        check("sw_dbg", dbg[0][2], 32'hDEADBEEF);

        for (int i = 0; i < 5; i++) begin
            first[i] = 0;
            nlow[i] = 0;
            nresp[i] = 0;
            got[i] = '0;
        end
        @(negedge clk);
        drive(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            for (int i = 0; i < 5; i++) begin
                if (!rdy[i]) nlow[i]++;
                if (rv[i]) begin
                    nresp[i]++;
                    if (first[i] == 0) begin
                        first[i] = c;
                        got[i] = rd[i];
                    end
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("lat%0d_first", lats[i]), first[i], lats[i] + 1);
            check($sformatf("lat%0d_notready", lats[i]), nlow[i], lats[i]);
            check($sformatf("lat%0d_npulse", lats[i]), nresp[i], 1);
            check($sformatf("lat%0d_rdata", lats[i]), got[i], 32'hDEADBEEF);
        end

        @(negedge clk);
        drive(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("b2b0_v1", 32'(rv[1]), 1);
        check("b2b1_busy_ready", 32'(rdy[0]), 0);
        @(posedge clk);
        @(negedge clk);
        check("b2b0_v2", 32'(rv[1]), 1);
        check("b2b1_resp_v", 32'(rv[0]), 1);
        check("b2b1_resp_ready", 32'(rdy[0]), 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("b2b1_second_busy_v", 32'(rv[0]), 0);
        check("b2b1_second_busy_ready", 32'(rdy[0]), 0);
        @(negedge clk);
        check("b2b1_second_v", 32'(rv[0]), 1);
        check("b2b1_second_rdata", rd[0], 32'hDEADBEEF);
        repeat (12) @(negedge clk);

        xact(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, d, e, l);
        check("lw_lat", l, 2);
        check("lw_rdata", d, 32'hDEADBEEF);
        check("lw_err", 32'(e), 0);

        xact(1'b1, 2'b00, 1'b0, 32'hA, 32'h11, d, e, l);
        check("sb_merge", dbg[0][2], 32'hDE11BEEF);
        xact(1'b1, 2'b01, 1'b0, 32'h8, 32'h2233, d, e, l);
        check("sh_merge", dbg[0][2], 32'hDE112233);
        xact(1'b0, 2'b00, 1'b0, 32'hB, 32'h0, d, e, l);
        check("lb", d, 32'hFFFFFFDE);
        xact(1'b0, 2'b00, 1'b1, 32'hB, 32'h0, d, e, l);
        check("lbu", d, 32'h000000DE);
        xact(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, d, e, l);
        check("lh", d, 32'hFFFFDE11);
        xact(1'b0, 2'b01, 1'b1, 32'h8, 32'h0, d, e, l);
        check("lhu", d, 32'h00002233);

        @(negedge clk);
        drive(1'b1, 2'b10, 1'b0, 32'h0, 32'h12345678);
        @(posedge clk);
        #1 drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("haz_gap", 32'(rv[0]), 0);
        @(negedge clk);
        check("haz_v", 32'(rv[0]), 1);
        check("haz_rdata", rd[0], 32'h12345678);

        xact(1'b1, 2'b10, 1'b0, 32'h4, 32'h5A5A5A5A, d, e, l);
        for (int i = 0; i < 4; i++) begin
            xact(ev_we[i], ev_sz[i], 1'b0, ev_a[i], 32'hAAAAAAAA, d, e, l);
            check($sformatf("err%0d_lat", i), l, 1);
            check($sformatf("err%0d_flag", i), 32'(e), 1);
            check($sformatf("err%0d_rdata", i), d, 0);
            check($sformatf("err%0d_mem", i), dbg[0][ev_w[i]], ev_m[i]);
        end
        @(negedge clk);
        check("err_clear_idle", 32'(er[0]), 0);

        repeat (12) @(negedge clk);
        @(negedge clk);
        drive(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_busy", 32'(rdy[4]), 0);
        #2 reset = 1'b1;
        #1;
        check("midrst_valid", 32'(rv[4]), 0);
        check("midrst_ready", 32'(rdy[4]), 1);
        check("midrst_rdata", rd[4], 0);
        check("midrst_mem", dbg[4][2], 0);
        check("midrst_mem_main", dbg[0][0], 0);
        @(negedge clk) reset = 1'b0;
        nr = 0;
        repeat (12) begin
            @(negedge clk);
            if (rv[4]) nr++;
        end
        check("midrst_noresp", nr, 0);
        check("midrst_ready_after", 32'(rdy[4]), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
